// File: rtl/rr_arb_mux.sv
// Registered N-way valid/ready arbiter-mux with round-robin or fixed-priority grant.
// Optional RR_ARB_MUX_COUNT_EN adds a wrapping 16-bit input-transfer counter port.
module rr_arb_mux #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = 0,
   localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SEL_W-1:0]          out_chan
`ifdef RR_ARB_MUX_COUNT_EN
   ,
   output logic [15:0]               xfer_count
`endif
);

   logic             accept;
   logic             gnt_found;
   logic [SEL_W-1:0] gnt_idx;
   logic [SEL_W-1:0] cand_idx;
   logic [WIDTH-1:0] sel_data;
   logic             xfer;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [SEL_W-1:0] out_chan_q, out_chan_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;

   assign accept = !out_valid_q || out_ready;

   // Search order starts just after the last winner in round-robin mode, at 0 otherwise.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (MODE == 1) begin
            cand_idx = SEL_W'(k);
         end else begin
            cand_idx = SEL_W'((32'(ptr_q) + k + 32'd1) % CHANNELS);
         end
         if (!gnt_found && in_valid[cand_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

   assign sel_data = in_data[32'(gnt_idx)*WIDTH +: WIDTH];
   assign xfer     = accept && gnt_found && !reset;

   always_comb begin
      in_ready = '0;
      if (xfer) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      ptr_d       = ptr_q;
      if (accept) begin
         out_valid_d = gnt_found;
         if (gnt_found) begin
            out_data_d = sel_data;
            out_chan_d = gnt_idx;
            if (MODE == 0) begin
               ptr_d = gnt_idx;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_chan_q  <= '0;
         ptr_q       <= SEL_W'(CHANNELS - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

`ifdef RR_ARB_MUX_COUNT_EN
   logic [15:0] xfer_cnt_q, xfer_cnt_d;

   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (xfer) begin
         xfer_cnt_d = xfer_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: round-robin instance checked against a reference model,
// plus a fixed-priority instance checked with directed expectations.
module tb_rr_arb_mux;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_chan;

   logic [3:0]  fp_valid;
   logic [3:0]  fp_ready;
   logic [7:0]  fp_data;
   logic        fp_ovalid;
   logic        fp_oready;
   logic [1:0]  fp_chan;

`ifdef RR_ARB_MUX_COUNT_EN
   logic [15:0] xfer_count;
   logic [15:0] fp_count;
`endif

   always #5 clock = ~clock;

   rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_rr (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_chan  (out_chan)
`ifdef RR_ARB_MUX_COUNT_EN
      ,
      .xfer_count(xfer_count)
`endif
   );

   rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_fp (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (fp_valid),
      .in_ready  (fp_ready),
      .out_data  (fp_data),
      .out_valid (fp_ovalid),
      .out_ready (fp_oready),
      .out_chan  (fp_chan)
`ifdef RR_ARB_MUX_COUNT_EN
      ,
      .xfer_count(fp_count)
`endif
   );

   typedef struct packed {
      logic [1:0] chan;
      logic [7:0] data;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sbq[$];
   logic [1:0]  grants[$];
   logic        m_ov    = 1'b0;
   logic [1:0]  m_ptr   = 2'd3;
   logic [7:0]  last_data;
   logic [1:0]  last_chan;
   logic [3:0]  cap_ready;
   logic [3:0]  cap_fp_ready;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: predict grant from the model, push the expected word, then check outputs.
   task automatic tick();
      logic       acc, found, dut_load;
      logic [1:0] g, c;
      logic [3:0] er;
      exp_t       e;
      #1;
      acc   = !m_ov || out_ready;
      found = 1'b0;
      g     = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         c = m_ptr + 2'(k);
         if (!found && in_valid[c]) begin
            found = 1'b1;
            g     = c;
         end
      end
      er = (acc && found && !reset) ? (4'b0001 << g) : 4'b0000;
      cap_ready    = in_ready;
      cap_fp_ready = fp_ready;
      check_eq("in_ready", 32'(in_ready), 32'(er));
      dut_load = (!out_valid || out_ready) && (|in_valid) && !reset;
      if (er != 4'b0000) begin
         e.chan = g;
         e.data = in_data[32'(g)*8 +: 8];
         sbq.push_back(e);
      end
      if (reset) begin
         m_ov  = 1'b0;
         m_ptr = 2'd3;
      end else if (acc) begin
         m_ov = found;
         if (found) m_ptr = g;
      end
      @(posedge clock);
      #1;
      check_eq("out_valid", 32'(out_valid), 32'(m_ov));
      if (out_valid && dut_load) begin
         check_eq("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check_eq("out_chan", 32'(out_chan), 32'(e.chan));
            check_eq("out_data", 32'(out_data), 32'(e.data));
            last_data = e.data;
            last_chan = e.chan;
         end
         grants.push_back(out_chan);
      end else if (out_valid) begin
         check_eq("hold_data", 32'(out_data), 32'(last_data));
         check_eq("hold_chan", 32'(out_chan), 32'(last_chan));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] exp_sparse [4];
      exp_sparse[0] = 2'd1;
      exp_sparse[1] = 2'd3;
      exp_sparse[2] = 2'd1;
      exp_sparse[3] = 2'd3;

      in_data   = {8'h43, 8'h32, 8'h21, 8'h10};
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      fp_valid  = 4'b0000;
      fp_oready = 1'b1;
      reset     = 1'b1;

      // Reset with all channels requesting.
      tick();
      tick();
      check_eq("rst_ready", 32'(cap_ready), 32'd0);
      check_eq("rst_data", 32'(out_data), 32'd0);
      check_eq("rst_chan", 32'(out_chan), 32'd0);
      reset = 1'b0;

      // Round-robin fairness over all four channels.
      grants.delete();
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) check_eq("first_ready", 32'(cap_ready), 32'b0001);
      end
      check_eq("rr_count", 32'(grants.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check_eq("rr_grant", 32'(grants[i]), 32'(i % 4));
      end

      // Backpressure with channel 2 registered.
      for (int i = 0; i < 3; i++) tick();
      check_eq("bp_chan0", 32'(out_chan), 32'd2);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("bp_ready", 32'(cap_ready), 32'd0);
         check_eq("bp_data", 32'(out_data), 32'h32);
         check_eq("bp_chan", 32'(out_chan), 32'd2);
      end
      out_ready = 1'b1;
      tick();
      check_eq("bp_release", 32'(cap_ready), 32'b1000);
      check_eq("bp_next", 32'(out_chan), 32'd3);

      // Sparse requesters with wrap, then a bubble.
      in_valid = 4'b1010;
      grants.delete();
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 4; i++) begin
         check_eq("sparse_grant", 32'(grants[i]), 32'(exp_sparse[i]));
      end
      in_valid = 4'b0000;
      tick();
      check_eq("bubble", 32'(out_valid), 32'd0);

      // Fixed priority instance: channel 1 always beats channel 3.
      fp_valid = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_eq("fp_ready", 32'(cap_fp_ready), 32'b0010);
         check_eq("fp_chan", 32'(fp_chan), 32'd1);
         check_eq("fp_data", 32'(fp_data), 32'h21);
      end
      fp_valid = 4'b1000;
      tick();
      check_eq("fp_ready3", 32'(cap_fp_ready), 32'b1000);
      check_eq("fp_chan3", 32'(fp_chan), 32'd3);
      check_eq("fp_data3", 32'(fp_data), 32'h43);
      fp_valid = 4'b0000;

      // Reset in the middle of a transfer discards the word and rewinds the pointer.
      in_valid = 4'b1111;
      tick();
      reset = 1'b1;
      tick();
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      reset = 1'b0;
      tick();
      check_eq("mid_rst_ready", 32'(cap_ready), 32'b0001);

`ifdef RR_ARB_MUX_COUNT_EN
      reset = 1'b1;
      tick();
      check_eq("cnt_rst", 32'(xfer_count), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_eq("cnt_5", 32'(xfer_count), 32'd5);
      for (int i = 0; i < 65530; i++) tick();
      check_eq("cnt_max", 32'(xfer_count), 32'hFFFF);
      tick();
      check_eq("cnt_wrap", 32'(xfer_count), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      check_eq("cnt_mid_rst", 32'(xfer_count), 32'd0);
      reset = 1'b0;
`endif

      in_valid = 4'b0000;
      tick();
      check_eq("sb_drain", 32'(sbq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered successor to the team's 2:1/4:1 gate-level muxes.
- Selects one of CHANNELS requesters, each WIDTH bits wide with valid/ready handshakes, and forwards it through one output register.
- Grant policy is round-robin or fixed-priority.
- Sits between multiple producers (e.g. register-file or ALU result sources) and a single shared consumer.

Parameters:
- WIDTH, 8: data bits per channel.
- CHANNELS, 4: number of input channels, 1 or more.
- MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- Derived localparam SEL_W = max(1, clog2(CHANNELS)); this is not overridable.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel request/valid.
- in_ready  output  CHANNELS  per-channel accept, one-hot or zero.
- out_data  output  WIDTH  registered selected data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_chan  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset values:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority after reset.
  - in_ready is forced to all-zero while reset=1.
- accept = !out_valid | out_ready. This is combinational, so the output register may be refilled in the same cycle it drains.
- Grant, combinational from in_valid and ptr only (never from in_ready):
  - MODE 0: first valid channel searching ptr+1, ptr+2, … with wrap modulo CHANNELS.
  - MODE 1: lowest-index valid channel; ptr is ignored.
- in_ready[g] = accept & in_valid[g] & !reset. All other in_ready bits are 0. At most one bit is high.
- On a transfer (accept with some valid channel g):
  - out_data <= slice g.
  - out_chan <= g.
  - out_valid <= 1.
  - ptr <= g (MODE 0 only).
- On accept with no valid channel: out_valid <= 0. out_data and out_chan hold their old values (don't-care).
- Stall (out_valid & !out_ready): out_data, out_chan, out_valid and ptr hold. in_ready is all-zero.
- Latency 1 cycle from input handshake to out_valid. Throughput 1 word/cycle with out_ready held high.
- Fairness (MODE 0): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0,…
- A requester never waits more than CHANNELS-1 transfers.
- CHANNELS=1: always grant 0; out_chan=0.
- Reset mid-transfer: the output word is discarded (out_valid=0 next cycle) and ptr returns to CHANNELS-1. Upstream must treat in_ready=0 during reset as no transfer.
- Inputs may drop in_valid without a handshake; the arbiter re-evaluates every cycle. Only the handshake cycle commits.

Optional Feature:
- Macro: RR_ARB_MUX_COUNT_EN.
- When defined:
  - Adds output port xfer_count [15:0], reset to 0.
  - Increments by 1 on every input transfer.
  - Wraps 0xFFFF -> 0x0000.
  - Does not change any other behaviour.
- When undefined: the port and counter logic are absent.

Test Plan:
- Reset then idle: reset=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_chan=0. On the first cycle after reset, in_ready=4'b0001.
- Round-robin, MODE 0, WIDTH 8, CHANNELS 4:
  - Stimulus: channel data 0x10,0x21,0x32,0x43, in_valid=4'b1111, out_ready=1 for 8 cycles.
  - Response: out_chan sequence 0,1,2,3,0,1,2,3; out_data 0x10,0x21,0x32,0x43 repeating; out_valid=1 from cycle 2 onward.
- Backpressure:
  - Stimulus: after channel 2 (data 0x32) is registered, out_ready=0 for 3 cycles.
  - Response: out_data stays 0x32, out_chan stays 2, in_ready=0. When out_ready=1 again, the next grant is channel 3 in the same cycle.
- Sparse/wrap:
  - Stimulus: only channels 1 and 3 valid, ptr at 3.
  - Response: grant order is 1,3,1,3. Bubble behaviour: when in_valid drops to 0 with out_ready=1, out_valid=0 the next cycle.
- Fixed priority, MODE 1:
  - Stimulus: in_valid=4'b1010 continuously.
  - Response: channel 1 is granted every cycle and channel 3 never. When channel 1 drops, channel 3 is granted next.
- With RR_ARB_MUX_COUNT_EN:
  - Stimulus: 5 transfers.
  - Response: xfer_count=5.
  - Stimulus: preload via 65535 transfers, then 1 more.
  - Response: xfer_count=0. A reset mid-run clears it to 0.
